// File: rtl/phrase_pkg.sv
// Shared parameters, FSM state type and address helper for the phrase
// bitmap ROM fetch sequencer.
package phrase_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 8;
    localparam int PHRASE_LEN = 16;
    localparam int ID_W       = 6;

    localparam int IDX_W = $clog2(PHRASE_LEN);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  index;
    } fifo_entry_t;

    // A phrase occupies an aligned block, so its base is the id with zero offset bits.
    function automatic logic [ADDR_W-1:0] phrase_base(input logic [ID_W-1:0] id);
        return {id, {IDX_W{1'b0}}};
    endfunction

endpackage

// File: rtl/phrase_fetch_ctrl_if.sv
// Byte stream towards the text renderer plus the ROM read pins, bundled so
// the sequencer owns both sides of the data path through one port.
interface phrase_fetch_ctrl_if;
    import phrase_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic              rom_enable;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;

    modport master (
        output out_valid, out_data, out_index, out_last, rom_enable, rom_address,
        input  out_ready, rom_data
    );

    modport slave (
        input  out_valid, out_data, out_index, out_last, rom_enable, rom_address,
        output out_ready, rom_data
    );

endinterface

// File: rtl/phrase_fifo2.sv
// Two-entry output FIFO holding returned ROM bytes with their phrase offset;
// flush discards everything, including a same-cycle push.
module phrase_fifo2
    import phrase_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [1:0]  count
);

    fifo_entry_t [1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/phrase_fetch_ctrl.sv
// Phrase fetch sequencer: reads one phrase from the bitmap ROM and streams it
// to the renderer with backpressure, keeping at most two bytes buffered or in flight.
module phrase_fetch_ctrl
    import phrase_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [ID_W-1:0]  phrase_id,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    phrase_fetch_ctrl_if.master bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [IDX_W-1:0]  returned_q, returned_d;
    logic              rom_enable_q, rom_enable_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;

    logic              flush;
    logic              push;
    logic              pop;
    logic              issue;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    fifo_entry_t       head;
    fifo_entry_t       push_entry;

    assign pop        = bus.out_valid & bus.out_ready;
    assign push_entry = '{data: bus.rom_data, index: returned_q};
    // Slots committed after this edge: buffered + in flight, minus the byte leaving now.
    assign occupancy  = {1'b0, fifo_count} + {2'b0, rom_enable_q} - {2'b0, pop};

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        issued_d      = issued_q;
        returned_d    = returned_q;
        rom_enable_d  = 1'b0;
        rom_address_d = rom_address_q;
        flush         = 1'b0;
        push          = rom_enable_q;
        issue         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    base_d     = phrase_base(phrase_id);
                    issued_d   = '0;
                    returned_d = '0;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                    push    = 1'b0;
                end else begin
                    issue = (issued_q < CNT_W'(PHRASE_LEN)) && (occupancy < 3'd2);
                    if (issue) begin
                        rom_enable_d  = 1'b1;
                        rom_address_d = base_q + ADDR_W'(issued_q[IDX_W-1:0]);
                        issued_d      = issued_q + CNT_W'(1);
                    end
                    if (push) begin
                        returned_d = returned_q + IDX_W'(1);
                    end
                    if (pop && bus.out_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                flush   = abort;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            issued_q      <= '0;
            returned_q    <= '0;
            rom_enable_q  <= 1'b0;
            rom_address_q <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            issued_q      <= issued_d;
            returned_q    <= returned_d;
            rom_enable_q  <= rom_enable_d;
            rom_address_q <= rom_address_d;
        end
    end

    phrase_fifo2 u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    assign busy            = (state_q == FETCH);
    assign done            = (state_q == DONE);
    assign bus.out_valid   = (fifo_count != 2'd0);
    assign bus.out_data    = head.data;
    assign bus.out_index   = head.index;
    assign bus.out_last    = (head.index == IDX_W'(PHRASE_LEN - 1));
    assign bus.rom_enable  = rom_enable_q;
    assign bus.rom_address = rom_address_q;

endmodule
